// File: rtl/fetch_stage.sv
// fetch_stage: PC register, combinational imem addressing and IF/ID register with stall, redirect/flush, boot bubble and fetch fault
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        stall_d,
  input  logic        redirect_e,
  input  logic [31:0] target_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fault_d
);
  typedef enum logic {BOOT, RUN} state_t;
  localparam logic [31:0] LIMIT = 32'(4 * IMEM_WORDS);
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_instr, r_pcd, r_p4, w_pc_plus4;
  logic        r_valid, r_fault, r_mis, w_flt, w_redir, w_capture;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= BOOT;
    else     r_state <= w_next;
  always_comb begin
    w_next     = (r_state == BOOT) ? RUN : r_state;
    w_redir    = (r_state == RUN) && redirect_e;
    w_capture  = (r_state == RUN) && !redirect_e && !stall_d;
    w_pc_plus4 = r_pc + 32'd4;
    w_flt      = (r_pc >= LIMIT) || r_mis;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_pcd   <= '0;
      r_p4    <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_mis   <= 1'b0;
    end else if (w_redir) begin
      r_pc    <= {target_e[31:2], 2'b00};
      r_mis   <= |target_e[1:0];
      r_instr <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (w_capture) begin
      r_pc    <= w_pc_plus4;
      r_instr <= w_flt ? 32'h0000_0013 : imem_rd;
      r_pcd   <= r_pc;
      r_p4    <= w_pc_plus4;
      r_valid <= 1'b1;
      r_fault <= w_flt;
      r_mis   <= 1'b0;
    end
  assign imem_addr  = r_pc;
  assign instr_d    = r_instr;
  assign pc_d       = r_pcd;
  assign pc_plus4_d = r_p4;
  assign valid_d    = r_valid;
  assign fault_d    = r_fault;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed check of fetch_stage against a behavioural fetch model
module tb_fetch_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] imem_addr, imem_rd, target_e = '0;
  logic        stall_d = 1'b0, redirect_e = 1'b0;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, fault_d;
  logic [31:0] mem [0:1023];
  int          n_chk = 0, n_err = 0;
  bit          m_boot, m_mis, m_valid, m_fault;
  logic [31:0] m_pc, m_instr, m_pcd, m_p4;
  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .stall_d(stall_d), .redirect_e(redirect_e), .target_e(target_e),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .fault_d(fault_d)
  );
  always #5 clk = ~clk;
  always_comb imem_rd = (imem_addr < 32'd4096) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_boot = 1; m_mis = 0; m_valid = 0; m_fault = 0;
    m_pc = 32'h0; m_instr = '0; m_pcd = '0; m_p4 = '0;
  endtask
  task automatic model_edge();
    bit f;
    if (m_boot) m_boot = 0;
    else if (redirect_e) begin
      m_pc = target_e & ~32'd3;
      m_mis = target_e[1:0] != 2'b00;
      m_valid = 0; m_instr = '0; m_fault = 0;
    end else if (!stall_d) begin
      f = (m_pc >= 32'd4096) || m_mis;
      m_instr = f ? 32'h13 : mem[m_pc[11:2]];
      m_pcd = m_pc; m_p4 = m_pc + 32'd4;
      m_valid = 1; m_fault = f; m_mis = 0;
      m_pc = m_pc + 32'd4;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".addr"}, imem_addr, m_pc);
    chk({tag, ".valid"}, {31'b0, valid_d}, {31'b0, m_valid});
    chk({tag, ".fault"}, {31'b0, fault_d}, {31'b0, m_fault});
    chk({tag, ".instr"}, instr_d, m_instr);
    chk({tag, ".pc_d"}, pc_d, m_pcd);
    chk({tag, ".pc4"}, pc_plus4_d, m_p4);
  endtask
  task automatic step(input string tag, input logic st, input logic rd, input logic [31:0] tg);
    stall_d = st; redirect_e = rd; target_e = tg;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    chk({tag, ".rst_valid"}, {31'b0, valid_d}, 32'd0);
    chk({tag, ".rst_addr"}, imem_addr, 32'h0);
    check_all({tag, ".rst"});
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    model_reset();
    #1 check_all("por");
    @(negedge clk);
    rst = 1'b0;
    step("t1e1", 0, 0, 0);
    chk("t1.boot_bubble", {31'b0, valid_d}, 32'd0);
    step("t1e2", 0, 0, 0);
    chk("t1.A", instr_d, mem[0]);
    step("t1e3", 0, 0, 0);
    chk("t1.B_pc4", pc_plus4_d, 32'd8);
    for (int i = 0; i < 3; i++) step("t2stall", 1, 0, 0);
    chk("t2.hold_addr", imem_addr, 32'd8);
    chk("t2.hold_instr", instr_d, mem[1]);
    step("t2rel", 0, 0, 0);
    chk("t2.C", instr_d, mem[2]);
    step("t3redir", 1, 1, 32'h40);
    chk("t3.pc", imem_addr, 32'h40);
    step("t3cap", 0, 0, 0);
    chk("t3.mem16", instr_d, mem[16]);
    step("t4redir", 0, 1, 32'h42);
    step("t4cap", 0, 0, 0);
    chk("t4.nop", instr_d, 32'h13);
    step("t4cap2", 0, 0, 0);
    chk("t4.clear", {31'b0, fault_d}, 32'd0);
    step("t5redir", 0, 1, 32'hFF8);
    for (int i = 0; i < 3; i++) step("t5run", 0, 0, 0);
    chk("t5.fault", {31'b0, fault_d}, 32'd1);
    chk("t5.pc", pc_d, 32'h1000);
    step("t5wrapr", 0, 1, 32'hFFFF_FFFF);
    step("t5wrap", 0, 0, 0);
    chk("t5.wrap_addr", imem_addr, 32'h0);
    step("t5after", 0, 0, 0);
    chk("t6.pre_valid", {31'b0, valid_d}, 32'd1);
    do_reset("t6");
    step("t6boot", 0, 0, 0);
    step("t6run", 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd");
      else step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h1100)));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
